baud_tick_gen_prog: RTL and testbench



---
 rtl/baud_pkg.sv | 32 +++
 rtl/baud_tick_divider.sv | 79 +++++++
 rtl/baud_tick_gen_prog.sv | 89 ++++++++
 tb/tb_baud_tick_gen_prog.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared constants and constant helper functions for the baud tick generator.
package baud_pkg;

   localparam int DEFAULT_ACC_WIDTH = 24;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input longint unsigned value);
      int r;
      r = 0;
      while ((64'd1 << r) < value) begin
         r++;
      end
      return r;
   endfunction

   // Width of the oversample index; a single-phase divider still keeps one bit.
   function automatic int phase_width(input int os);
      return clog2((os > 2) ? os : 2);
   endfunction

   // Accumulator increment for a target tick rate, rounded to nearest.
   // The 64-bit numerator holds baud*os*2^acc_width for any realistic UART rate.
   function automatic logic [63:0] calc_inc(input longint unsigned clk_hz,
                                            input longint unsigned baud,
                                            input longint unsigned os,
                                            input int              acc_width);
      longint unsigned num;
      num = (baud * os) << acc_width;
      return (num + (clk_hz / 2)) / clk_hz;
   endfunction

endpackage

// File: rtl/baud_tick_divider.sv
// Divides the accumulator carry into oversampling, mid-bit and bit-boundary ticks.
module baud_tick_divider
   import baud_pkg::*;
#(
   parameter  int OVERSAMPLING = 16,
   localparam int PHASE_W      = phase_width(OVERSAMPLING)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               resync,
   input  logic               carry,
   output logic               bit_set,
   output logic               os_tick,
   output logic               bit_tick,
   output logic               sample_tick,
   output logic [PHASE_W-1:0] os_phase
);

   localparam int               MID       = OVERSAMPLING / 2;
   localparam logic [PHASE_W-1:0] LAST      = PHASE_W'(OVERSAMPLING - 1);
   localparam logic [PHASE_W-1:0] SAMPLE_AT = (MID > 0) ? PHASE_W'(MID - 1) : '0;

   logic [PHASE_W-1:0] os_phase_q, os_phase_d;
   logic               os_tick_q, os_tick_d;
   logic               bit_tick_q, bit_tick_d;
   logic               sample_tick_q, sample_tick_d;
   logic               step;
   logic               at_last;
   logic               at_sample;

   // Next-state: advance the oversample index on every qualified carry.
   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch is inferred.
      os_phase_d    = os_phase_q;
      os_tick_d     = 1'b0;
      bit_tick_d    = 1'b0;
      sample_tick_d = 1'b0;

      step      = enable & ~resync & carry;
      at_last   = (os_phase_q == LAST);
      // With a single phase every tick is also the mid-bit tick.
      at_sample = (OVERSAMPLING == 1) ? 1'b1 : (os_phase_q == SAMPLE_AT);

      if (!enable || resync) begin
         os_phase_d = '0;
      end else if (step) begin
         os_phase_d    = at_last ? '0 : os_phase_q + PHASE_W'(1);
         os_tick_d     = 1'b1;
         bit_tick_d    = at_last;
         sample_tick_d = at_sample;
      end
   end

   // The top applies a pending increment on the same edge the bit tick is set.
   assign bit_set = bit_tick_d;

   // Register index and ticks so every output is a flop.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) begin
         os_phase_q    <= '0;
         os_tick_q     <= 1'b0;
         bit_tick_q    <= 1'b0;
         sample_tick_q <= 1'b0;
      end else begin
         os_phase_q    <= os_phase_d;
         os_tick_q     <= os_tick_d;
         bit_tick_q    <= bit_tick_d;
         sample_tick_q <= sample_tick_d;
      end
   end

   assign os_tick     = os_tick_q;
   assign bit_tick    = bit_tick_q;
   assign sample_tick = sample_tick_q;
   assign os_phase    = os_phase_q;

endmodule

// File: rtl/baud_tick_gen_prog.sv
// Programmable fractional-N baud tick generator: phase accumulator plus
// glitch-free increment reload that lands only on a bit boundary.
module baud_tick_gen_prog
   import baud_pkg::*;
#(
   parameter int                   ACC_WIDTH    = DEFAULT_ACC_WIDTH,
   parameter int                   OVERSAMPLING = 16,
   parameter logic [ACC_WIDTH-1:0] DEFAULT_INC  = ACC_WIDTH'(1855),
   localparam int                  PHASE_W      = phase_width(OVERSAMPLING)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 resync,
   input  logic [ACC_WIDTH-1:0] inc_data,
   input  logic                 inc_valid,
   output logic                 inc_ready,
   output logic                 os_tick,
   output logic                 bit_tick,
   output logic                 sample_tick,
   output logic [PHASE_W-1:0]   os_phase
);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] inc_active_q, inc_active_d;
   logic [ACC_WIDTH-1:0] pending_q, pending_d;
   logic                 inc_ready_q, inc_ready_d;
   logic [ACC_WIDTH:0]   sum;
   logic                 bit_set;
   logic                 xfer;
   logic                 apply;

   // Accumulate and manage the single-entry increment update slot.
   always_comb begin
      sum   = {1'b0, acc_q} + {1'b0, inc_active_q};
      acc_d = (!enable || resync) ? '0 : sum[ACC_WIDTH-1:0];

      // A slot that is free cannot also be applied, so a transfer on an
      // apply edge only fills the slot and waits for the next boundary.
      xfer  = inc_valid & inc_ready_q;
      apply = ~inc_ready_q & (bit_set | ~enable | resync);

      inc_active_d = apply ? pending_q : inc_active_q;
      pending_d    = xfer ? inc_data : pending_q;

      inc_ready_d = inc_ready_q;
      if (apply) begin
         inc_ready_d = 1'b1;
      end
      if (xfer) begin
         inc_ready_d = 1'b0;
      end
   end

   // State registers for the accumulator and the update handshake.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q        <= '0;
         inc_active_q <= DEFAULT_INC;
         // NOTE: the pending data register is reset as well; it is one word and
         // keeps X out of inc_active if a bit boundary were ever mis-qualified.
         pending_q    <= '0;
         inc_ready_q  <= 1'b1;
      end else begin
         acc_q        <= acc_d;
         inc_active_q <= inc_active_d;
         pending_q    <= pending_d;
         inc_ready_q  <= inc_ready_d;
      end
   end

   assign inc_ready = inc_ready_q;

   baud_tick_divider #(
      .OVERSAMPLING (OVERSAMPLING)
   ) u_divider (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .resync      (resync),
      .carry       (sum[ACC_WIDTH]),
      .bit_set     (bit_set),
      .os_tick     (os_tick),
      .bit_tick    (bit_tick),
      .sample_tick (sample_tick),
      .os_phase    (os_phase)
   );

endmodule

// File: tb/tb_baud_tick_gen_prog.sv
// Self-checking bench: two generators (4x and 1x oversampling) share one
// stimulus stream and are compared every cycle against a rate model.
module tb_baud_tick_gen_prog;

   localparam int          W       = 16;
   localparam int unsigned DEF_INC = 32'h4000;
   localparam int unsigned MODULUS = 32'h1_0000;

   logic         clk;
   logic         reset;
   logic         enable;
   logic         resync;
   logic [W-1:0] inc_data;
   logic         inc_valid;

   logic         rdy0, os0, bt0, st0;
   logic [1:0]   ph0;
   logic         rdy1, os1, bt1, st1;
   logic [0:0]   ph1;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   // Model state, index 0 = 4x oversampling, index 1 = 1x oversampling.
   int unsigned m_acc[2];
   int unsigned m_inc[2];
   int unsigned m_pend[2];
   int          m_cnt[2];   // ticks since the phase was last cleared
   bit          m_rdy[2];
   bit          m_os[2];
   bit          m_bit[2];
   bit          m_smp[2];

   baud_tick_gen_prog #(
      .ACC_WIDTH    (W),
      .OVERSAMPLING (4),
      .DEFAULT_INC  (W'(DEF_INC))
   ) dut0 (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .resync      (resync),
      .inc_data    (inc_data),
      .inc_valid   (inc_valid),
      .inc_ready   (rdy0),
      .os_tick     (os0),
      .bit_tick    (bt0),
      .sample_tick (st0),
      .os_phase    (ph0)
   );

   baud_tick_gen_prog #(
      .ACC_WIDTH    (W),
      .OVERSAMPLING (1),
      .DEFAULT_INC  (W'(DEF_INC))
   ) dut1 (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .resync      (resync),
      .inc_data    (inc_data),
      .inc_valid   (inc_valid),
      .inc_ready   (rdy1),
      .os_tick     (os1),
      .bit_tick    (bt1),
      .sample_tick (st1),
      .os_phase    (ph1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s @cycle %0d: observed %0h required %0h", tag, cyc, obs, exp);
      end
   endtask

   // Rate model: tick when the running phase sum wraps past 2^W; bit and
   // sample ticks are picked from the tick count since the last phase clear.
   task automatic model_step(input int m);
      int              os;
      int              ph;
      longint unsigned s;
      bit              xfer;
      bit              apply;
      bit              bit_now;
      os = (m == 0) ? 4 : 1;
      if (reset) begin
         m_acc[m] = 0; m_cnt[m] = 0; m_inc[m] = DEF_INC; m_pend[m] = 0;
         m_rdy[m] = 1'b1; m_os[m] = 1'b0; m_bit[m] = 1'b0; m_smp[m] = 1'b0;
      end else begin
         xfer    = inc_valid && m_rdy[m];
         bit_now = 1'b0;
         if (!enable || resync) begin
            m_acc[m] = 0; m_cnt[m] = 0;
            m_os[m] = 1'b0; m_bit[m] = 1'b0; m_smp[m] = 1'b0;
         end else begin
            s        = longint'(m_acc[m]) + longint'(m_inc[m]);
            m_os[m]  = (s >= MODULUS);
            m_acc[m] = int'(s % MODULUS);
            if (m_os[m]) begin
               ph       = m_cnt[m] % os;
               m_bit[m] = (ph == os - 1);
               m_smp[m] = (os == 1) || (ph == os / 2 - 1);
               m_cnt[m]++;
            end else begin
               m_bit[m] = 1'b0;
               m_smp[m] = 1'b0;
            end
            bit_now = m_bit[m];
         end
         apply = !m_rdy[m] && (bit_now || !enable || resync);
         if (apply) begin
            m_inc[m] = m_pend[m];
            m_rdy[m] = 1'b1;
         end
         if (xfer) begin
            m_pend[m] = inc_data;
            m_rdy[m]  = 1'b0;
         end
      end
   endtask

   task automatic check_outputs();
      check("os_tick_os4",     os0,  m_os[0]);
      check("bit_tick_os4",    bt0,  m_bit[0]);
      check("sample_tick_os4", st0,  m_smp[0]);
      check("os_phase_os4",    ph0,  m_cnt[0] % 4);
      check("inc_ready_os4",   rdy0, m_rdy[0]);
      check("os_tick_os1",     os1,  m_os[1]);
      check("bit_tick_os1",    bt1,  m_bit[1]);
      check("sample_tick_os1", st1,  m_smp[1]);
      check("os_phase_os1",    ph1,  0);
      check("inc_ready_os1",   rdy1, m_rdy[1]);
   endtask

   // One clock: model takes the inputs present at the edge, outputs are sampled 1 time unit later.
   task automatic step();
      @(posedge clk);
      model_step(0);
      model_step(1);
      cyc++;
      #1;
      check_outputs();
   endtask

   // Steps n cycles and counts 4x-oversampling ticks.
   task automatic run_count(input int n, output int n_os, output int n_bit, output int n_smp);
      n_os = 0; n_bit = 0; n_smp = 0;
      for (int i = 0; i < n; i++) begin
         step();
         n_os  += int'(os0);
         n_bit += int'(bt0);
         n_smp += int'(st0);
      end
   endtask

   // Cycles until the next 4x os_tick, bounded; 0 if no tick within the bound.
   task automatic first_tick(output int k);
      k = 0;
      for (int i = 1; i <= 200; i++) begin
         step();
         if (os0 && k == 0) begin
            k = i;
            break;
         end
      end
   endtask

   initial begin
      int n_os, n_bit, n_smp, k;

      reset = 1'b1; enable = 1'b0; resync = 1'b0; inc_valid = 1'b0; inc_data = '0;
      step();
      step();

      // Default rate 0x4000: tick every 4 cycles, bit every 16.
      reset  = 1'b0;
      enable = 1'b1;
      run_count(32, n_os, n_bit, n_smp);
      check("default_os_ticks_32cyc",     n_os,  8);
      check("default_bit_ticks_32cyc",    n_bit, 2);
      check("default_sample_ticks_32cyc", n_smp, 2);

      // Reload mid-bit to 0x8000; a second offer while the slot is full is ignored.
      run_count(5, n_os, n_bit, n_smp);
      inc_data = W'(16'h8000); inc_valid = 1'b1;
      step();
      inc_data = W'(16'h1000);
      repeat (3) step();
      inc_valid = 1'b0;
      run_count(32, n_os, n_bit, n_smp);

      // Resync restarts the phase; 0x8000 gives the first tick after 2 cycles.
      run_count(3, n_os, n_bit, n_smp);
      resync = 1'b1;
      step();
      resync = 1'b0;
      first_tick(k);
      check("resync_latency", k, 2);
      run_count(20, n_os, n_bit, n_smp);

      // Enable low mid-bit for 3 cycles, then a fresh phase.
      run_count(3, n_os, n_bit, n_smp);
      enable = 1'b0;
      run_count(3, n_os, n_bit, n_smp);
      check("disabled_ticks", n_os + n_bit + n_smp, 0);
      enable = 1'b1;
      first_tick(k);
      check("reenable_latency", k, 2);

      // Zero increment silences the generator.
      inc_data = '0; inc_valid = 1'b1;
      step();
      inc_valid = 1'b0;
      run_count(20, n_os, n_bit, n_smp);
      run_count(100, n_os, n_bit, n_smp);
      check("zero_inc_no_ticks", n_os, 0);

      // 0xFFFF waits for resync (no bit boundary while silent), then ticks nearly every cycle.
      inc_data = W'(16'hFFFF); inc_valid = 1'b1;
      step();
      inc_valid = 1'b0;
      run_count(50, n_os, n_bit, n_smp);
      check("max_inc_still_pending", n_os, 0);
      resync = 1'b1;
      step();
      resync = 1'b0;
      run_count(300, n_os, n_bit, n_smp);
      check("max_inc_ticks_300cyc", n_os, 299);

      // Reset with an update pending restores the default rate.
      inc_data = W'(16'h2000); inc_valid = 1'b1;
      step();
      inc_valid = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      run_count(16, n_os, n_bit, n_smp);
      check("post_reset_os_ticks_16cyc", n_os, 4);

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         enable    = ($urandom_range(0, 99) != 0);
         resync    = ($urandom_range(0, 99) == 0);
         reset     = ($urandom_range(0, 499) == 0);
         inc_valid = ($urandom_range(0, 7) == 0);
         inc_data  = W'($urandom_range(16'h0400, 16'h9000));
         step();
      end
      reset = 1'b0; enable = 1'b0; resync = 1'b0; inc_valid = 1'b0;
      step();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
